// File: rtl/video_stream_pkg.sv
// Shared Avalon-ST video definitions: packet type codes, receiver states,
// control-packet nibble lanes and the decoded control payload.
package video_stream_pkg;

    localparam int unsigned DATA_W        = 24;
    localparam int unsigned DIM_W         = 16;
    localparam int unsigned NIB_W         = 4;
    localparam int unsigned NIBS_PER_BEAT = 3;
    localparam int unsigned BEAT_NIB_W    = NIB_W * NIBS_PER_BEAT;
    localparam int unsigned CTRL_BEATS    = 3;

    localparam int unsigned PKT_TYPE_LSB = 0;
    localparam int unsigned NIB0_LSB     = 0;
    localparam int unsigned NIB1_LSB     = 8;
    localparam int unsigned NIB2_LSB     = 16;

    localparam logic [NIB_W-1:0] PKT_VIDEO = 4'h0;
    localparam logic [NIB_W-1:0] PKT_CTRL  = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CTRL  = 2'd1,
        ST_VIDEO = 2'd2,
        ST_SKIP  = 2'd3
    } rx_state_e;

    typedef struct packed {
        logic [DIM_W-1:0] width;
        logic [DIM_W-1:0] height;
        logic [NIB_W-1:0] interlace;
    } ctrl_fields_t;

    localparam int unsigned CTRL_W = $bits(ctrl_fields_t);

    // Nibbles of one control beat, most significant first.
    function automatic logic [BEAT_NIB_W-1:0] beat_nibbles(input logic [DATA_W-1:0] d);
        return {d[NIB0_LSB +: NIB_W], d[NIB1_LSB +: NIB_W], d[NIB2_LSB +: NIB_W]};
    endfunction

endpackage

// File: rtl/video_stream_rx_if.sv
// Avalon-ST sink plus pixel output stream of the video receiver.
interface video_stream_rx_if;
    import video_stream_pkg::*;

    logic [DATA_W-1:0] din_data;
    logic              din_valid;
    logic              din_startofpacket;
    logic              din_endofpacket;
    logic              din_ready;

    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;
    logic [DIM_W-1:0]  pix_x;
    logic [DIM_W-1:0]  pix_y;
    logic              pix_sof;
    logic              pix_eol;

    modport master (
        output din_data, din_valid, din_startofpacket, din_endofpacket, pix_ready,
        input  din_ready, pix_data, pix_valid, pix_x, pix_y, pix_sof, pix_eol
    );

    modport slave (
        input  din_data, din_valid, din_startofpacket, din_endofpacket, pix_ready,
        output din_ready, pix_data, pix_valid, pix_x, pix_y, pix_sof, pix_eol
    );

endinterface

// File: rtl/video_stream_ctrl_decoder.sv
// Collects the nine control-packet nibbles and commits width/height/interlace
// only for a well-formed three-beat packet with nonzero dimensions.
module video_stream_ctrl_decoder
    import video_stream_pkg::*;
#(
    parameter int unsigned DEFAULT_WIDTH  = 1920,
    parameter int unsigned DEFAULT_HEIGHT = 1080
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  hdr_eop,
    input  logic                  beat,
    input  logic                  eop,
    input  logic [BEAT_NIB_W-1:0] nib,
    output ctrl_fields_t          fields,
    output logic                  ctrl_update,
    output logic                  err_ctrl
);

    localparam int unsigned HIST_W = CTRL_W - BEAT_NIB_W;

    logic [1:0]        beat_cnt;
    logic [HIST_W-1:0] hist;
    logic [CTRL_W-1:0] cand_v;
    ctrl_fields_t      cand;

    assign cand_v = {hist, nib};
    assign cand   = ctrl_fields_t'(cand_v);

    // beat_cnt saturates at CTRL_BEATS to flag over-long packets.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt    <= '0;
            hist        <= '0;
            fields      <= '{width:     DIM_W'(DEFAULT_WIDTH),
                             height:    DIM_W'(DEFAULT_HEIGHT),
                             interlace: '0};
            ctrl_update <= 1'b0;
            err_ctrl    <= 1'b0;
        end else begin
            ctrl_update <= 1'b0;
            err_ctrl    <= 1'b0;
            if (clear) begin
                beat_cnt <= '0;
                if (hdr_eop) err_ctrl <= 1'b1;
            end else if (beat) begin
                if (beat_cnt != 2'(CTRL_BEATS)) begin
                    hist     <= cand_v[HIST_W-1:0];
                    beat_cnt <= beat_cnt + 2'd1;
                end
                if (eop) begin
                    if (beat_cnt == 2'(CTRL_BEATS - 1) && cand.width != '0 && cand.height != '0) begin
                        fields      <= cand;
                        ctrl_update <= 1'b1;
                    end else begin
                        err_ctrl <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/video_stream_rx.sv
// Avalon-ST video receiver: parses control/video packets and emits pixels
// with x/y coordinates, frame markers and protocol error pulses.
module video_stream_rx
    import video_stream_pkg::*;
#(
    parameter int unsigned DEFAULT_WIDTH  = 1920,
    parameter int unsigned DEFAULT_HEIGHT = 1080
) (
    input  logic               clk,
    input  logic               reset_n,
    video_stream_rx_if.slave   bus,
    output logic [DIM_W-1:0]   frame_width,
    output logic [DIM_W-1:0]   frame_height,
    output logic [NIB_W-1:0]   interlace,
    output logic               ctrl_update,
    output logic               frame_done,
    output logic [DIM_W-1:0]   frame_count,
    output logic               err_short,
    output logic               err_long,
    output logic               err_ctrl,
    output logic               err_abort
);

    rx_state_e        state, state_nxt;
    ctrl_fields_t     fields;
    logic             fire, sop_fire, data_fire, video_beat, hdr_eop;
    logic [NIB_W-1:0] pkt_type;
    logic [DIM_W-1:0] cur_w, cur_h, x_cnt, y_cnt;
    logic             full, long_seen, last_x, last_y;

    assign bus.din_ready = !bus.pix_valid || bus.pix_ready;
    assign fire          = bus.din_valid && bus.din_ready;
    assign sop_fire      = fire && bus.din_startofpacket;
    assign data_fire     = fire && !bus.din_startofpacket;
    assign pkt_type      = bus.din_data[PKT_TYPE_LSB +: NIB_W];
    assign video_beat    = data_fire && (state == ST_VIDEO);
    assign hdr_eop       = sop_fire && bus.din_endofpacket && (pkt_type == PKT_CTRL);
    assign last_x        = (x_cnt == cur_w - DIM_W'(1));
    assign last_y        = (y_cnt == cur_h - DIM_W'(1));

    assign frame_width  = fields.width;
    assign frame_height = fields.height;
    assign interlace    = fields.interlace;

    video_stream_ctrl_decoder #(
        .DEFAULT_WIDTH  (DEFAULT_WIDTH),
        .DEFAULT_HEIGHT (DEFAULT_HEIGHT)
    ) u_ctrl_decoder (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (sop_fire),
        .hdr_eop     (hdr_eop),
        .beat        (data_fire && (state == ST_CTRL)),
        .eop         (bus.din_endofpacket),
        .nib         (beat_nibbles(bus.din_data)),
        .fields      (fields),
        .ctrl_update (ctrl_update),
        .err_ctrl    (err_ctrl)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Any SOP re-decodes a header; any EOP ends the packet.
    always_comb begin
        state_nxt = state;
        if (sop_fire) begin
            if (pkt_type == PKT_CTRL)       state_nxt = ST_CTRL;
            else if (pkt_type == PKT_VIDEO) state_nxt = ST_VIDEO;
            else                            state_nxt = ST_SKIP;
            if (bus.din_endofpacket)        state_nxt = ST_IDLE;
        end else if (data_fire && bus.din_endofpacket) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.pix_valid <= 1'b0;
            bus.pix_data  <= '0;
            bus.pix_x     <= '0;
            bus.pix_y     <= '0;
            bus.pix_sof   <= 1'b0;
            bus.pix_eol   <= 1'b0;
            x_cnt         <= '0;
            y_cnt         <= '0;
            full          <= 1'b0;
            long_seen     <= 1'b0;
            cur_w         <= DIM_W'(DEFAULT_WIDTH);
            cur_h         <= DIM_W'(DEFAULT_HEIGHT);
            frame_done    <= 1'b0;
            frame_count   <= '0;
            err_short     <= 1'b0;
            err_long      <= 1'b0;
            err_abort     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            err_long   <= 1'b0;
            err_abort  <= 1'b0;
            if (bus.pix_valid && bus.pix_ready) bus.pix_valid <= 1'b0;

            if (sop_fire) begin
                err_abort <= (state != ST_IDLE);
                // Dimensions are frozen here so control packets never touch a live frame.
                if (pkt_type == PKT_VIDEO) begin
                    x_cnt     <= '0;
                    y_cnt     <= '0;
                    full      <= 1'b0;
                    long_seen <= 1'b0;
                    cur_w     <= fields.width;
                    cur_h     <= fields.height;
                    if (bus.din_endofpacket) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + DIM_W'(1);
                        err_short   <= 1'b1;
                    end
                end
            end else if (video_beat) begin
                if (!full) begin
                    bus.pix_valid <= 1'b1;
                    bus.pix_data  <= bus.din_data;
                    bus.pix_x     <= x_cnt;
                    bus.pix_y     <= y_cnt;
                    bus.pix_sof   <= (x_cnt == '0) && (y_cnt == '0);
                    bus.pix_eol   <= last_x;
                    if (last_x) begin
                        x_cnt <= '0;
                        if (last_y) full  <= 1'b1;
                        else        y_cnt <= y_cnt + DIM_W'(1);
                    end else begin
                        x_cnt <= x_cnt + DIM_W'(1);
                    end
                end else if (!long_seen) begin
                    err_long  <= 1'b1;
                    long_seen <= 1'b1;
                end
                if (bus.din_endofpacket) begin
                    frame_done  <= 1'b1;
                    frame_count <= frame_count + DIM_W'(1);
                    err_short   <= !(full || (last_x && last_y));
                end
            end
        end
    end

endmodule

// File: tb/tb_video_stream_rx.sv
// Directed bench for video_stream_rx with an 8x4 default raster.
module tb_video_stream_rx;
    import video_stream_pkg::*;

    localparam int unsigned W = 8;
    localparam int unsigned H = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    video_stream_rx_if bus ();

    logic [15:0] frame_width, frame_height, frame_count;
    logic [3:0]  interlace;
    logic        ctrl_update, frame_done, err_short, err_long, err_ctrl, err_abort;

    video_stream_rx #(.DEFAULT_WIDTH(W), .DEFAULT_HEIGHT(H)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus.slave),
        .frame_width  (frame_width),
        .frame_height (frame_height),
        .interlace    (interlace),
        .ctrl_update  (ctrl_update),
        .frame_done   (frame_done),
        .frame_count  (frame_count),
        .err_short    (err_short),
        .err_long     (err_long),
        .err_ctrl     (err_ctrl),
        .err_abort    (err_abort)
    );

    int checks = 0;
    int errors = 0;

    // Pulse counters and pixel log, sampled on the falling edge.
    int n_upd = 0, n_done = 0, n_short = 0, n_long = 0, n_ctrl = 0, n_abort = 0;
    logic [23:0] q_data[$];
    logic [15:0] q_x[$], q_y[$];
    logic        q_sof[$], q_eol[$];

    always @(negedge clk) begin
        if (ctrl_update) n_upd++;
        if (frame_done)  n_done++;
        if (err_short)   n_short++;
        if (err_long)    n_long++;
        if (err_ctrl)    n_ctrl++;
        if (err_abort)   n_abort++;
        if (bus.pix_valid && bus.pix_ready) begin
            q_data.push_back(bus.pix_data);
            q_x.push_back(bus.pix_x);
            q_y.push_back(bus.pix_y);
            q_sof.push_back(bus.pix_sof);
            q_eol.push_back(bus.pix_eol);
        end
    end

    int b_upd, b_done, b_short, b_long, b_ctrl, b_abort, b_px;

    task automatic snap();
        b_upd = n_upd; b_done = n_done; b_short = n_short; b_long = n_long;
        b_ctrl = n_ctrl; b_abort = n_abort; b_px = q_data.size();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [23:0] d, input logic s, input logic e);
        logic ok;
        int   tries;
        ok = 1'b0;
        tries = 0;
        @(negedge clk);
        bus.din_data = d;
        bus.din_valid = 1'b1;
        bus.din_startofpacket = s;
        bus.din_endofpacket = e;
        while (!ok && tries < 64) begin
            #4;
            ok = bus.din_ready;
            @(posedge clk);
            tries++;
            if (!ok) @(negedge clk);
        end
        #1;
        bus.din_valid = 1'b0;
        if (!ok) check("beat_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic send_ctrl(input logic [15:0] w, input logic [15:0] h,
                             input logic [3:0] il, input int nbeats);
        logic [35:0] v;
        logic [3:0]  n0, n1, n2;
        v = {w, h, il};
        send(24'hA5A5AF, 1'b1, 1'b0);
        for (int b = 0; b < nbeats; b++) begin
            n0 = v[35 - 12*b -: 4];
            n1 = v[31 - 12*b -: 4];
            n2 = v[27 - 12*b -: 4];
            send({4'hA, n2, 4'hA, n1, 4'hA, n0}, 1'b0, b == nbeats - 1);
        end
    endtask

    task automatic send_video(input logic [23:0] base, input int n);
        send(24'hABCDE0, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) send(base + 24'(i), 1'b0, i == n - 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [7:0] eolv;

        bus.din_data = '0;
        bus.din_valid = 1'b0;
        bus.din_startofpacket = 1'b0;
        bus.din_endofpacket = 1'b0;
        bus.pix_ready = 1'b1;

        // Reset values
        idle(3);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_pix_xy", {bus.pix_x, bus.pix_y}, 32'd0);
        check("rst_pix_data", 32'(bus.pix_data), 32'd0);
        check("rst_dims", {frame_width, frame_height}, {16'd8, 16'd4});
        check("rst_interlace", 32'(interlace), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_pulses", 32'({ctrl_update, frame_done, err_short, err_long, err_ctrl, err_abort}), 32'd0);
        check("rst_din_ready", 32'(bus.din_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // 8x4 control packet then a full 32-pixel frame
        snap();
        send_ctrl(16'd8, 16'd4, 4'd0, 3);
        idle(3);
        check("ctrl84_update", 32'(n_upd - b_upd), 32'd1);
        check("ctrl84_dims", {frame_width, frame_height}, {16'd8, 16'd4});
        send_video(24'h100000, 32);
        idle(3);
        check("f1_pixels", 32'(q_data.size() - b_px), 32'd32);
        check("f1_last_xy", {q_x[q_x.size()-1], q_y[q_y.size()-1]}, {16'd7, 16'd3});
        check("f1_last_data", 32'(q_data[q_data.size()-1]), 32'h10001F);
        check("f1_first_sof", 32'({q_sof[b_px], q_sof[b_px+1]}), 32'b10);
        check("f1_done", 32'(n_done - b_done), 32'd1);
        check("f1_count", 32'(frame_count), 32'd1);
        check("f1_errors", 32'((n_short + n_long + n_ctrl + n_abort) - (b_short + b_long + b_ctrl + b_abort)), 32'd0);
        check("f1_drained", 32'(bus.pix_valid), 32'd0);

        // 4x2 control packet, eol every 4th pixel
        snap();
        send_ctrl(16'd4, 16'd2, 4'd5, 3);
        idle(3);
        check("ctrl42_update", 32'(n_upd - b_upd), 32'd1);
        check("ctrl42_dims", {frame_width, frame_height}, {16'd4, 16'd2});
        check("ctrl42_interlace", 32'(interlace), 32'd5);
        snap();
        send_video(24'h200000, 8);
        idle(3);
        eolv = '0;
        for (int i = 0; i < 8; i++) eolv[i] = q_eol[b_px + i];
        check("f2_eol_pattern", 32'(eolv), 32'h88);
        check("f2_last_xy", {q_x[q_x.size()-1], q_y[q_y.size()-1]}, {16'd3, 16'd1});
        check("f2_count", 32'(frame_count), 32'd2);

        // Back to 8x4; unknown packet type is skipped silently
        send_ctrl(16'd8, 16'd4, 4'd0, 3);
        idle(2);
        snap();
        send(24'h000005, 1'b1, 1'b0);
        send(24'h000001, 1'b0, 1'b0);
        send(24'h000002, 1'b0, 1'b1);
        idle(3);
        check("skip_pixels", 32'(q_data.size() - b_px), 32'd0);
        check("skip_errors", 32'((n_short + n_long + n_ctrl + n_abort + n_done) - (b_short + b_long + b_ctrl + b_abort + b_done)), 32'd0);

        // Short frame
        snap();
        send_video(24'h300000, 30);
        idle(3);
        check("short_err", 32'(n_short - b_short), 32'd1);
        check("short_done", 32'(n_done - b_done), 32'd1);
        check("short_pixels", 32'(q_data.size() - b_px), 32'd30);

        // Long frame
        snap();
        send_video(24'h400000, 35);
        idle(3);
        check("long_err_once", 32'(n_long - b_long), 32'd1);
        check("long_pixels", 32'(q_data.size() - b_px), 32'd32);
        check("long_no_short", 32'(n_short - b_short), 32'd0);
        check("long_count", 32'(frame_count), 32'd4);

        // Downstream stall for 10 cycles mid-frame
        snap();
        send(24'hABCDE0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send(24'h500000 + 24'(i), 1'b0, 1'b0);
        bus.pix_ready = 1'b0;
        @(negedge clk);
        bus.din_data = 24'h50000A;
        bus.din_valid = 1'b1;
        bus.din_startofpacket = 1'b0;
        bus.din_endofpacket = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.din_ready !== 1'b0 || bus.pix_valid !== 1'b1 || bus.pix_data !== 24'h500009) bad++;
            @(negedge clk);
        end
        check("stall_hold", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        bus.din_valid = 1'b0;
        bus.pix_ready = 1'b1;
        for (int i = 10; i < 32; i++) send(24'h500000 + 24'(i), 1'b0, i == 31);
        idle(3);
        bad = 0;
        for (int i = 0; i < 32; i++) if (q_data[b_px + i] !== 24'h500000 + 24'(i)) bad++;
        check("stall_pixels", 32'(q_data.size() - b_px), 32'd32);
        check("stall_order", 32'(bad), 32'd0);
        check("stall_count", 32'(frame_count), 32'd5);

        // SOP during video after 12 pixels restarts the frame
        snap();
        send(24'hABCDE0, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) send(24'h600000 + 24'(i), 1'b0, 1'b0);
        send_video(24'h700000, 32);
        idle(3);
        check("abort_err", 32'(n_abort - b_abort), 32'd1);
        check("abort_pixels", 32'(q_data.size() - b_px), 32'd44);
        check("abort_restart", {q_x[b_px+12], q_y[b_px+12]}, 32'd0);
        check("abort_restart_sof", 32'(q_sof[b_px+12]), 32'd1);
        check("abort_restart_data", 32'(q_data[b_px+12]), 32'h700000);
        check("abort_done", 32'(n_done - b_done), 32'd1);
        check("abort_count", 32'(frame_count), 32'd6);

        // Bad control packets leave dimensions alone
        snap();
        send_ctrl(16'd0, 16'd4, 4'd3, 3);
        idle(3);
        check("ctrl_w0_err", 32'(n_ctrl - b_ctrl), 32'd1);
        send_ctrl(16'd5, 16'd2, 4'd1, 2);
        idle(3);
        check("ctrl_short_err", 32'(n_ctrl - b_ctrl), 32'd2);
        check("ctrl_bad_no_update", 32'(n_upd - b_upd), 32'd0);
        check("ctrl_bad_dims", {frame_width, frame_height}, {16'd8, 16'd4});
        check("ctrl_bad_interlace", 32'(interlace), 32'd0);

        // Reset in the middle of a 6x3 frame
        send_ctrl(16'd6, 16'd3, 4'd9, 3);
        idle(3);
        check("ctrl63_dims", {frame_width, frame_height}, {16'd6, 16'd3});
        send(24'hABCDE0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) send(24'h800000 + 24'(i), 1'b0, 1'b0);
        idle(2);
        reset_n = 1'b0;
        #1;
        check("mid_rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("mid_rst_pix_xy", {bus.pix_x, bus.pix_y}, 32'd0);
        check("mid_rst_pix_data", 32'(bus.pix_data), 32'd0);
        check("mid_rst_dims", {frame_width, frame_height}, {16'd8, 16'd4});
        check("mid_rst_interlace", 32'(interlace), 32'd0);
        check("mid_rst_count", 32'(frame_count), 32'd0);
        check("mid_rst_pulses", 32'({ctrl_update, frame_done, err_short, err_long, err_ctrl, err_abort}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);
        snap();
        send(24'h800005, 1'b0, 1'b0);
        send(24'h800006, 1'b0, 1'b0);
        send(24'h800007, 1'b0, 1'b1);
        idle(3);
        check("post_rst_dropped", 32'(q_data.size() - b_px), 32'd0);
        check("post_rst_no_done", 32'(n_done - b_done), 32'd0);
        snap();
        send_video(24'h900000, 32);
        idle(3);
        check("post_rst_pixels", 32'(q_data.size() - b_px), 32'd32);
        check("post_rst_last_xy", {q_x[q_x.size()-1], q_y[q_y.size()-1]}, {16'd7, 16'd3});
        check("post_rst_count", 32'(frame_count), 32'd1);
        check("post_rst_no_short", 32'(n_short - b_short), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/video_stream_rx.md
VIDEO_STREAM_RX -- requirements
Module: video_stream_rx

Interface
REQ-001 SHALL have parameter DEFAULT_WIDTH, default 1920: active width used until a valid control packet is received.
REQ-002 SHALL have parameter DEFAULT_HEIGHT, default 1080: active height used until a valid control packet is received.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 din_data  in  24  Avalon-ST sink data.
REQ-006 din_valid  in  1  sink beat valid.
REQ-007 din_startofpacket  in  1  first beat of packet.
REQ-008 din_endofpacket  in  1  last beat of packet.
REQ-009 din_ready  out  1  sink ready, readyLatency 0.
REQ-010 pix_data  out  24  pixel value.
REQ-011 pix_valid  out  1  pixel output valid.
REQ-012 pix_ready  in  1  downstream accepts pixel.
REQ-013 pix_x, pix_y  out  16 each  pixel coordinates.
REQ-014 pix_sof / pix_eol  out  1 each  first pixel of frame / last pixel of line.
REQ-015 frame_width, frame_height  out  16 each  active dimensions; interlace  out  4  last received interlace nibble.
REQ-016 ctrl_update  out  1  one-cycle pulse: new dimensions accepted.
REQ-017 frame_done  out  1  one-cycle pulse at video packet EOP; frame_count  out  16  frames completed, wraps.
REQ-018 err_short / err_long / err_ctrl / err_abort  out  1 each  one-cycle error pulses.

Function
REQ-019 Beat transfer SHALL occur iff din_valid && din_ready; din_ready = !pix_valid || pix_ready.
REQ-020 States SHALL be IDLE, CTRL, VIDEO, SKIP; IDLE ignores beats without SOP.
REQ-021 SOP beat: din_data[3:0]=0xF -> CTRL; 0x0 -> VIDEO; other -> SKIP; header beat never emits a pixel.
REQ-022 CTRL SHALL collect 3 beats, nibbles din_data[3:0],[11:8],[19:16] per beat, MSB first: W[15:12],W[11:8],W[7:4],W[3:0],H[15:12],H[11:8],H[7:4],H[3:0],interlace.
REQ-023 On 3rd CTRL beat with EOP and W,H both nonzero: update frame_width/height/interlace, pulse ctrl_update next cycle; otherwise retain previous values, pulse err_ctrl.
REQ-024 EOP before 3rd CTRL beat SHALL pulse err_ctrl; extra beats after 3rd SHALL be discarded until EOP and pulse err_ctrl.
REQ-025 VIDEO: each non-header beat while count < W*H SHALL register to pix_data with 1-cycle latency, x/y from counters; pix_sof when x=0,y=0; pix_eol when x=W-1.
REQ-026 x increments per pixel, wraps to 0 at W-1 with y+1; counters reset to 0 at every video SOP.
REQ-027 Beats beyond W*H pixels SHALL be dropped and pulse err_long once per packet.
REQ-028 EOP with fewer than W*H pixels SHALL pulse err_short; every video EOP SHALL pulse frame_done and increment frame_count.
REQ-029 SKIP discards beats until EOP, then IDLE; EOP on any state returns to IDLE.
REQ-030 SOP while in CTRL/VIDEO/SKIP SHALL pulse err_abort and be decoded as a new header (REQ-021) in the same cycle.
REQ-031 Dimensions SHALL be sampled at video SOP; a control packet never alters an in-progress frame.
REQ-032 pix_valid held with stable data while pix_ready low.

Reset
REQ-033 reset_n low: state IDLE, pix_valid 0, pix_data/pix_x/pix_y 0, all pulses 0, frame_count 0, frame_width=DEFAULT_WIDTH, frame_height=DEFAULT_HEIGHT, interlace 0.
REQ-034 Reset mid-packet SHALL discard remaining beats until next SOP.

Structure
REQ-035 Packet type codes (0x0, 0xF), state encodings and nibble lane positions SHALL live in shared package video_stream_pkg, also used by the TPG.
REQ-036 Sub-module video_stream_ctrl_decoder SHALL hold CTRL nibble collection and validation.

Verification
REQ-037 W=8,H=4 params; ctrl packet 8x4 then video 32 pixels -> 32 pix_valid, last pix_x=7,pix_y=3, frame_done, frame_count=1, no errors.
REQ-038 Ctrl packet W=4,H=2 -> ctrl_update, frame_width=4, frame_height=2; next video 8 pixels -> pix_eol at beats 4 and 8.
REQ-039 Video with 30 pixels (W=8,H=4) -> err_short, frame_done; with 35 -> err_long once, only 32 pixels out.
REQ-040 pix_ready low 10 cycles mid-frame -> din_ready low, pix_data stable, no pixel lost or duplicated.
REQ-041 SOP during video at pixel 12 -> err_abort, counters restart, new frame from pix_x=0.
REQ-042 Ctrl with W=0 or only 2 beats -> err_ctrl, dimensions unchanged; reset_n asserted mid-frame -> all outputs at REQ-033 values.
